// File: rtl/inst_fetch_unit.sv
// rtl/inst_fetch_unit.sv - instruction fetch unit: cache query, byte-wise miss refill, cache fill
//
// Purpose:
//   Initiator between the IF stage, a direct-mapped instruction cache and a
//   byte-wide memory port. A hit returns the cached word one cycle after the
//   query. A miss reads four sequential bytes, assembles a little-endian word,
//   writes it back through the cache fill port and returns it to IF.
//
// Ports:
//   clk, rst                 clock; synchronous active-low reset
//   if_req, if_addr          fetch request (level) and PC, low two bits ignored
//   if_flush                 abort current fetch (redirect)
//   if_valid, if_inst        one-cycle result pulse and fetched word
//   cache_query, query_addr  combinational lookup strobe and aligned address
//   inst_hit_i, inst_cache_i same-cycle cache response
//   cache_enable, fill_addr, fill_data   one-cycle cache fill write
//   mem_req, mem_addr        byte read request and byte address
//   mem_busy_i               request not accepted this cycle
//   mem_data_i               byte returned one cycle after acceptance

module inst_fetch_unit #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_valid,
    output logic [INST_W-1:0] if_inst,
    output logic              cache_query,
    output logic [ADDR_W-1:0] query_addr,
    input  logic              inst_hit_i,
    input  logic [INST_W-1:0] inst_cache_i,
    output logic              cache_enable,
    output logic [ADDR_W-1:0] fill_addr,
    output logic [INST_W-1:0] fill_data,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_busy_i,
    input  logic [7:0]        mem_data_i
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] base_q;
    logic [2:0]        issue_cnt_q;
    logic [2:0]        recv_cnt_q;
    logic              rx_pend_q;
    logic [INST_W-1:0] data_q;
    logic              if_valid_q;
    logic [INST_W-1:0] if_inst_q;
    logic              cache_en_q;
    logic [ADDR_W-1:0] fill_addr_q;
    logic [INST_W-1:0] fill_data_q;

    logic              accept;
    logic              capture;
    logic [ADDR_W-1:0] aligned_addr;
    logic [INST_W-1:0] data_d;
    logic [1:0]        unused_addr_bits;

    assign unused_addr_bits = if_addr[1:0];
    assign aligned_addr     = {if_addr[ADDR_W-1:2], 2'b00};

    assign cache_query = (state_q == S_IDLE) && if_req && !if_flush;
    assign query_addr  = cache_query ? aligned_addr : '0;

    // Flush gates the request combinationally so nothing is accepted in the
    // redirect cycle.
    assign mem_req  = (state_q == S_FETCH) && (issue_cnt_q < 3'd4) && !if_flush;
    assign mem_addr = mem_req ? (base_q + {{(ADDR_W-3){1'b0}}, issue_cnt_q}) : '0;
    assign accept   = mem_req && !mem_busy_i;

    // A byte is on mem_data_i in the cycle after its acceptance; a flush in
    // that cycle discards it.
    assign capture = rx_pend_q && (state_q == S_FETCH) && !if_flush;

    // Bytes return in issue order, so the receive counter selects the lane.
    always_comb begin
        data_d = data_q;
        if (capture) begin
            case (recv_cnt_q[1:0])
                2'd0:    data_d[7:0]   = mem_data_i;
                2'd1:    data_d[15:8]  = mem_data_i;
                2'd2:    data_d[23:16] = mem_data_i;
                default: data_d[31:24] = mem_data_i;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            base_q      <= '0;
            issue_cnt_q <= '0;
            recv_cnt_q  <= '0;
            rx_pend_q   <= 1'b0;
            data_q      <= '0;
            if_valid_q  <= 1'b0;
            if_inst_q   <= '0;
            cache_en_q  <= 1'b0;
            fill_addr_q <= '0;
            fill_data_q <= '0;
        end else begin
            if_valid_q <= 1'b0;
            cache_en_q <= 1'b0;
            rx_pend_q  <= accept;

            if (if_flush) begin
                state_q <= S_IDLE;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (if_req) begin
                            if (inst_hit_i) begin
                                if_valid_q <= 1'b1;
                                if_inst_q  <= inst_cache_i;
                            end else begin
                                base_q      <= aligned_addr;
                                issue_cnt_q <= '0;
                                recv_cnt_q  <= '0;
                                data_q      <= '0;
                                state_q     <= S_FETCH;
                            end
                        end
                    end
                    S_FETCH: begin
                        if (accept) begin
                            issue_cnt_q <= issue_cnt_q + 3'd1;
                        end
                        if (capture) begin
                            data_q     <= data_d;
                            recv_cnt_q <= recv_cnt_q + 3'd1;
                            // Last byte: present fill and result together in DONE.
                            if (recv_cnt_q == 3'd3) begin
                                state_q     <= S_DONE;
                                cache_en_q  <= 1'b1;
                                fill_addr_q <= base_q;
                                fill_data_q <= data_d;
                                if_valid_q  <= 1'b1;
                                if_inst_q   <= data_d;
                            end
                        end
                    end
                    S_DONE: begin
                        state_q <= S_IDLE;
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign if_valid     = if_valid_q;
    assign if_inst      = if_inst_q;
    assign cache_enable = cache_en_q;
    assign fill_addr    = fill_addr_q;
    assign fill_data    = fill_data_q;

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
Sits between the IF stage, the direct-mapped instruction cache and the byte-wide memory port. It is the initiator side of the cache interface: it issues cache queries, and on a miss it assembles a 32-bit instruction from four sequential byte reads. It then writes the line back through the cache fill port and returns the instruction to IF.

Parameters:
ADDR_W, 32, width of instruction and memory addresses.
INST_W, 32, instruction width; fixed at 4 bytes, little-endian.

Ports:
clk  input  1  clock.
rst  input  1  reset; synchronous, active-low.
if_req  input  1  IF requests the instruction at if_addr; level, held until if_valid or flush.
if_addr  input  ADDR_W  fetch PC; bits [1:0] ignored and treated as 00.
if_flush  input  1  abort the current fetch (branch redirect).
if_valid  output  1  one-cycle pulse; if_inst is valid.
if_inst  output  INST_W  fetched instruction.
cache_query  output  1  cache lookup strobe.
query_addr  output  ADDR_W  lookup address.
inst_hit_i  input  1  cache hit, combinational response to the query in the same cycle.
inst_cache_i  input  INST_W  cached instruction, valid when inst_hit_i=1.
cache_enable  output  1  fill-write strobe, one cycle.
fill_addr  output  ADDR_W  address being filled (word aligned).
fill_data  output  INST_W  assembled instruction.
mem_req  output  1  byte read request.
mem_addr  output  ADDR_W  byte address.
mem_busy_i  input  1  memory arbiter stall; the request is not accepted this cycle.
mem_data_i  input  8  read byte, valid exactly 1 cycle after an accepted request.

Behaviour:
- Reset (rst=0 at posedge):
  - state=IDLE.
  - if_valid=0, if_inst=0, cache_enable=0, fill_addr=0, fill_data=0, mem_req=0, mem_addr=0.
  - Byte counters cleared.
  - Reset mid-fetch discards all partial data; no fill is issued.
- cache_query=1 and query_addr={if_addr[ADDR_W-1:2],2'b00} are combinational whenever state=IDLE, if_req=1 and if_flush=0. Both are 0 otherwise.
- Request acceptance: in a cycle with mem_req=1 and mem_busy_i=0. A byte is captured from mem_data_i in the cycle following each acceptance.
- States:
  - IDLE:
    - if_req & !if_flush & inst_hit_i: latch inst_cache_i. Next cycle if_valid=1, if_inst=cached word (hit latency 1). Stay IDLE.
    - if_req & !if_flush & !inst_hit_i: latch base address, issue_cnt=0, recv_cnt=0 -> FETCH.
  - FETCH:
    - mem_req=1 while issue_cnt<4; mem_addr=base+issue_cnt.
    - issue_cnt increments on each acceptance.
    - Byte k from mem_data_i goes to data[8k+7:8k] when captured; recv_cnt increments.
    - After recv_cnt reaches 4 -> DONE.
    - Best-case miss latency: 4 issue cycles + 1 data cycle + 1 DONE = 6 cycles from the query cycle to if_valid.
  - DONE (one cycle):
    - cache_enable=1, fill_addr=base, fill_data=assembled word.
    - if_valid=1, if_inst=assembled word, in the same cycle.
    - -> IDLE.
- if_flush=1 in any state:
  - Next state is IDLE.
  - if_valid and cache_enable are forced to 0 in the following cycle.
  - mem_req drops the same cycle (combinationally gated).
  - Any byte returning next cycle is ignored.
  - Flush has priority over a hit and over DONE.
- mem_busy_i=1: mem_addr and issue_cnt hold. Returning data for earlier accepted bytes is still captured.
- if_req dropping while in FETCH without a flush: the fill still completes and writes the cache; if_valid still pulses.
- Address arithmetic: base+issue_cnt uses ADDR_W bits and wraps modulo 2^ADDR_W. Byte lanes use the counter, never the address.
- No new cache query while in FETCH/DONE. A query resumes in the IDLE cycle after DONE.

Test Plan:
- Hit: cache preloaded so inst_hit_i=1 with inst_cache_i=32'h00A00093 for if_addr=32'h104 -> query_addr=32'h104 the same cycle; next cycle if_valid=1, if_inst=32'h00A00093; mem_req never asserted.
- Miss fill: if_addr=32'h200, memory bytes 13,05,50,00 at 0x200..0x203, no busy -> mem_addr sequence 200,201,202,203. Six cycles after the query: cache_enable=1, fill_addr=32'h200, fill_data=32'h00500513, if_valid=1, if_inst=32'h00500513.
- Busy stall: same miss with mem_busy_i=1 on the 2nd and 3rd request cycles -> mem_addr holds 0x201 for 3 cycles; result is still 32'h00500513; if_valid is 2 cycles later than in the no-busy case.
- Flush mid-fetch: miss at 0x300, if_flush=1 after 2 bytes have been received -> IDLE next cycle; no cache_enable, no if_valid. The next if_req at 0x400 (miss) fetches cleanly, with bytes at 0x400.. not mixed with data from 0x300.
- Unaligned/wrap: if_addr=32'hFFFFFFFE -> query_addr=32'hFFFFFFFC; on a miss, mem_addr runs FFFFFFFC..FFFFFFFF; fill_addr=32'hFFFFFFFC.
- Reset mid-fetch: rst=0 during FETCH after 1 byte -> all outputs 0 next cycle; no fill after rst returns to 1 until a new if_req.
